// File: rtl/rrd_issue.sv
// Register-read / issue stage: resolves operands from the register file or the
// writeback bypass, tracks busy registers and registers up to num_lanes issued ops.
module rrd_issue #(
  parameter int s_index         = 5,
  parameter int s_width         = 32,
  parameter int num_lanes       = 2,
  parameter int num_write_ports = 2,
  parameter int s_tag           = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [num_lanes-1:0]       in_valid,
  input  logic [s_index-1:0]         in_src1      [num_lanes],
  input  logic [s_index-1:0]         in_src2      [num_lanes],
  input  logic [s_index-1:0]         in_dest      [num_lanes],
  input  logic [num_lanes-1:0]       in_has_dest,
  input  logic [s_tag-1:0]           in_tag       [num_lanes],
  output logic [num_lanes-1:0]       in_take,
  output logic [s_index-1:0]         rf_src       [2*num_lanes],
  input  logic [s_width-1:0]         rf_out       [2*num_lanes],
  input  logic [num_write_ports-1:0] wb_ld,
  input  logic [s_index-1:0]         wb_dest      [num_write_ports],
  input  logic [s_width-1:0]         wb_data      [num_write_ports],
  output logic [num_lanes-1:0]       out_valid,
  input  logic                       out_ready,
  output logic [s_width-1:0]         out_op1      [num_lanes],
  output logic [s_width-1:0]         out_op2      [num_lanes],
  output logic [s_index-1:0]         out_dest     [num_lanes],
  output logic [num_lanes-1:0]       out_has_dest,
  output logic [s_tag-1:0]           out_tag      [num_lanes]
);

  localparam int n_ports = 2 * num_lanes;
  localparam int n_regs  = 2 ** s_index;

  logic [n_regs-1:0]    busy_q, busy_d;
  logic [num_lanes-1:0] out_valid_q, out_valid_d;
  logic [num_lanes-1:0] out_has_dest_q, out_has_dest_d;
  logic [s_width-1:0]   out_op1_q  [num_lanes];
  logic [s_width-1:0]   out_op1_d  [num_lanes];
  logic [s_width-1:0]   out_op2_q  [num_lanes];
  logic [s_width-1:0]   out_op2_d  [num_lanes];
  logic [s_index-1:0]   out_dest_q [num_lanes];
  logic [s_index-1:0]   out_dest_d [num_lanes];
  logic [s_tag-1:0]     out_tag_q  [num_lanes];
  logic [s_tag-1:0]     out_tag_d  [num_lanes];

  logic [n_ports-1:0]   src_hit, src_rdy;
  logic [s_width-1:0]   src_byp  [n_ports];
  logic [s_width-1:0]   src_opnd [n_ports];
  logic [num_lanes-1:0] dst_hit, elig, take;
  logic                 can_load, prefix, conflict, dst_free, sb_clr, sb_set;

  always_comb begin
    for (int i = 0; i < num_lanes; i++) begin
      rf_src[2*i]   = in_src1[i];
      rf_src[2*i+1] = in_src2[i];
    end
    // Later write ports overwrite earlier ones, so the highest matching port supplies data.
    for (int k = 0; k < n_ports; k++) begin
      src_hit[k] = 1'b0;
      src_byp[k] = '0;
      for (int j = 0; j < num_write_ports; j++) begin
        src_byp[k] = (wb_ld[j] && wb_dest[j] == rf_src[k]) ? wb_data[j] : src_byp[k];
        src_hit[k] = src_hit[k] | (wb_ld[j] && wb_dest[j] == rf_src[k]);
      end
      src_hit[k]  = src_hit[k] & (rf_src[k] != '0);
      src_rdy[k]  = (rf_src[k] == '0) || !busy_q[rf_src[k]] || src_hit[k];
      src_opnd[k] = (rf_src[k] == '0) ? '0 : (src_hit[k] ? src_byp[k] : rf_out[k]);
    end
    for (int i = 0; i < num_lanes; i++) begin
      dst_hit[i] = 1'b0;
      for (int j = 0; j < num_write_ports; j++) begin
        dst_hit[i] = dst_hit[i] | (wb_ld[j] && wb_dest[j] == in_dest[i]);
      end
    end
  end

  always_comb begin
    can_load = ~(|out_valid_q) | out_ready;
    prefix   = can_load & rst_n;
    conflict = 1'b0;
    dst_free = 1'b0;
    for (int i = 0; i < num_lanes; i++) begin
      conflict = 1'b0;
      // An older lane's destination blocks a younger lane that reads or rewrites it.
      for (int j = 0; j < i; j++) begin
        conflict = conflict | (in_has_dest[j] && in_dest[j] != '0 &&
                               (in_src1[i] == in_dest[j] || in_src2[i] == in_dest[j] ||
                                (in_has_dest[i] && in_dest[i] == in_dest[j])));
      end
      dst_free = !in_has_dest[i] || in_dest[i] == '0 || !busy_q[in_dest[i]] || dst_hit[i];
      elig[i]  = in_valid[i] & src_rdy[2*i] & src_rdy[2*i+1] & dst_free & ~conflict;
      prefix   = prefix & elig[i];
      take[i]  = prefix;
    end
    in_take = take;
  end

  always_comb begin
    sb_clr = 1'b0;
    sb_set = 1'b0;
    for (int r = 0; r < n_regs; r++) begin
      sb_clr = 1'b0;
      sb_set = 1'b0;
      for (int j = 0; j < num_write_ports; j++) begin
        sb_clr = sb_clr | (wb_ld[j] && wb_dest[j] == s_index'(r));
      end
      for (int i = 0; i < num_lanes; i++) begin
        sb_set = sb_set | (take[i] && in_has_dest[i] && in_dest[i] == s_index'(r));
      end
      busy_d[r] = (r == 0) ? 1'b0 : (sb_set | (busy_q[r] & ~sb_clr));
    end
  end

  always_comb begin
    out_valid_d = can_load ? take : out_valid_q;
    for (int i = 0; i < num_lanes; i++) begin
      out_op1_d[i]      = take[i] ? src_opnd[2*i]   : out_op1_q[i];
      out_op2_d[i]      = take[i] ? src_opnd[2*i+1] : out_op2_q[i];
      out_dest_d[i]     = take[i] ? in_dest[i]      : out_dest_q[i];
      out_has_dest_d[i] = take[i] ? in_has_dest[i]  : out_has_dest_q[i];
      out_tag_d[i]      = take[i] ? in_tag[i]       : out_tag_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= '0;
      out_valid_q    <= '0;
      out_has_dest_q <= '0;
      for (int i = 0; i < num_lanes; i++) begin
        out_op1_q[i]  <= '0;
        out_op2_q[i]  <= '0;
        out_dest_q[i] <= '0;
        out_tag_q[i]  <= '0;
      end
    end else begin
      busy_q         <= busy_d;
      out_valid_q    <= out_valid_d;
      out_has_dest_q <= out_has_dest_d;
      for (int i = 0; i < num_lanes; i++) begin
        out_op1_q[i]  <= out_op1_d[i];
        out_op2_q[i]  <= out_op2_d[i];
        out_dest_q[i] <= out_dest_d[i];
        out_tag_q[i]  <= out_tag_d[i];
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_has_dest = out_has_dest_q;
  assign out_op1      = out_op1_q;
  assign out_op2      = out_op2_q;
  assign out_dest     = out_dest_q;
  assign out_tag      = out_tag_q;

endmodule

// File: tb/tb_rrd_issue.sv
// Directed bench for rrd_issue: hand-computed operand, take and scoreboard expectations.
module tb_rrd_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [4:0]  in_src1 [2];
  logic [4:0]  in_src2 [2];
  logic [4:0]  in_dest [2];
  logic [1:0]  in_has_dest;
  logic [7:0]  in_tag  [2];
  logic [1:0]  in_take;
  logic [4:0]  rf_src  [4];
  logic [31:0] rf_out  [4];
  logic [1:0]  wb_ld;
  logic [4:0]  wb_dest [2];
  logic [31:0] wb_data [2];
  logic [1:0]  out_valid;
  logic        out_ready;
  logic [31:0] out_op1 [2];
  logic [31:0] out_op2 [2];
  logic [4:0]  out_dest [2];
  logic [1:0]  out_has_dest;
  logic [7:0]  out_tag [2];

  int n_cmp = 0;
  int n_err = 0;

  rrd_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
    .in_has_dest(in_has_dest), .in_tag(in_tag), .in_take(in_take),
    .rf_src(rf_src), .rf_out(rf_out),
    .wb_ld(wb_ld), .wb_dest(wb_dest), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_dest(out_dest),
    .out_has_dest(out_has_dest), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int i, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic hd, input logic [7:0] t);
    in_valid[i]    = v;
    in_src1[i]     = s1;
    in_src2[i]     = s2;
    in_dest[i]     = d;
    in_has_dest[i] = hd;
    in_tag[i]      = t;
  endtask

  task automatic rf(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] c, input logic [31:0] d);
    rf_out[0] = a; rf_out[1] = b; rf_out[2] = c; rf_out[3] = d;
  endtask

  task automatic wb(input int p, input logic ld, input logic [4:0] d, input logic [31:0] data);
    wb_ld[p]   = ld;
    wb_dest[p] = d;
    wb_data[p] = data;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    wb(0, 1'b0, 5'd0, 32'h0);
    wb(1, 1'b0, 5'd0, 32'h0);
    lane(0, 1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 8'hA1);
    lane(1, 1'b1, 5'd5, 5'd6, 5'd4, 1'b1, 8'hB2);
    rf(32'd2, 32'd3, 32'd5, 32'd6);
    #1;
    check_eq("reset_take", 32'(in_take), 32'h0);
    check_eq("reset_valid", 32'(out_valid), 32'h0);
    check_eq("reset_op1", out_op1[0], 32'h0);
    check_eq("reset_tag", 32'(out_tag[1]), 32'h0);

    // Independent pair
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("pair_take", 32'(in_take), 32'h3);
    check_eq("rf_src0", 32'(rf_src[0]), 32'd2);
    check_eq("rf_src3", 32'(rf_src[3]), 32'd6);
    step();
    check_eq("pair_valid", 32'(out_valid), 32'h3);
    check_eq("pair_op1_0", out_op1[0], 32'd2);
    check_eq("pair_op2_0", out_op2[0], 32'd3);
    check_eq("pair_op1_1", out_op1[1], 32'd5);
    check_eq("pair_op2_1", out_op2[1], 32'd6);
    check_eq("pair_dest1", 32'(out_dest[1]), 32'd4);
    check_eq("pair_hd", 32'(out_has_dest), 32'h3);
    check_eq("pair_tag0", 32'(out_tag[0]), 32'hA1);
    check_eq("busy1", 32'(dut.busy_q[1]), 32'h1);
    check_eq("busy4", 32'(dut.busy_q[4]), 32'h1);

    // Stall, then reset asynchronously while stalled
    out_ready = 1'b0;
    #1;
    check_eq("stall_take", 32'(in_take), 32'h0);
    step();
    check_eq("stall_valid", 32'(out_valid), 32'h3);
    check_eq("stall_op1", out_op1[0], 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", 32'(out_valid), 32'h0);
    check_eq("rst_mid_busy", dut.busy_q, 32'h0);
    check_eq("rst_mid_take", 32'(in_take), 32'h0);

    // Intra-pair RAW on r7
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    lane(0, 1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 8'h01);
    lane(1, 1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 8'h02);
    rf(32'd10, 32'd20, 32'd30, 32'd40);
    #1;
    check_eq("raw_take", 32'(in_take), 32'h1);
    step();
    check_eq("raw_valid", 32'(out_valid), 32'h1);
    check_eq("raw_dest", 32'(out_dest[0]), 32'd7);
    lane(0, 1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 8'h02);
    lane(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00);
    rf(32'h1234, 32'h40, 32'h0, 32'h0);
    #1;
    check_eq("raw_stall_take", 32'(in_take), 32'h0);
    step();
    check_eq("raw_stall_valid", 32'(out_valid), 32'h0);
    wb(0, 1'b1, 5'd7, 32'hDEAD);
    #1;
    check_eq("raw_wb_take", 32'(in_take), 32'h1);
    step();
    check_eq("raw_byp_op1", out_op1[0], 32'hDEAD);
    check_eq("raw_byp_op2", out_op2[0], 32'h40);
    check_eq("raw_byp_tag", 32'(out_tag[0]), 32'h02);
    wb(0, 1'b0, 5'd0, 32'h0);

    // Dual-port bypass priority on r9
    lane(0, 1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 8'h09);
    #1;
    check_eq("r9_set_take", 32'(in_take), 32'h1);
    step();
    lane(0, 1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 8'h0A);
    rf(32'h99, 32'hFFFF, 32'h0, 32'h0);
    wb(0, 1'b1, 5'd9, 32'h11);
    wb(1, 1'b1, 5'd9, 32'h22);
    #1;
    check_eq("dual_take", 32'(in_take), 32'h1);
    step();
    check_eq("dual_op1", out_op1[0], 32'h22);
    check_eq("dual_op2_r0", out_op2[0], 32'h0);
    wb(0, 1'b0, 5'd0, 32'h0);
    wb(1, 1'b0, 5'd0, 32'h0);
    check_eq("busy9_clear", 32'(dut.busy_q[9]), 32'h0);
    lane(0, 1'b1, 5'd9, 5'd1, 5'd11, 1'b1, 8'h0B);
    rf(32'h55, 32'h66, 32'h0, 32'h0);
    #1;
    check_eq("r9_nostall_take", 32'(in_take), 32'h1);
    step();

    // Back-pressure for three cycles
    out_ready = 1'b0;
    lane(0, 1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 8'h0C);
    rf(32'h77, 32'h88, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("bp_take", 32'(in_take), 32'h0);
      check_eq("bp_valid", 32'(out_valid), 32'h1);
      check_eq("bp_op1", out_op1[0], 32'h55);
      check_eq("bp_dest", 32'(out_dest[0]), 32'd11);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_take", 32'(in_take), 32'h1);
    step();
    check_eq("bp_new_op1", out_op1[0], 32'h77);
    check_eq("bp_new_op2", out_op2[0], 32'h88);
    check_eq("bp_new_dest", 32'(out_dest[0]), 32'd12);

    // r0 sources, r0 writeback and r0 destination
    lane(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 8'h0D);
    rf(32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF);
    wb(0, 1'b1, 5'd0, 32'd5);
    #1;
    check_eq("r0_take", 32'(in_take), 32'h1);
    step();
    check_eq("r0_op1", out_op1[0], 32'h0);
    check_eq("r0_op2", out_op2[0], 32'h0);
    check_eq("busy0", 32'(dut.busy_q[0]), 32'h0);
    wb(0, 1'b0, 5'd0, 32'h0);
    lane(1, 1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 8'h0E);
    #1;
    check_eq("r0_pair_take", 32'(in_take), 32'h3);
    step();
    check_eq("r0_pair_valid", 32'(out_valid), 32'h3);
    check_eq("r0_pair_op1_1", out_op1[1], 32'h0);
    check_eq("r0_pair_dest1", 32'(out_dest[1]), 32'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
